// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display bus: segment patterns for each
// hex digit and the capture FSM state type.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    typedef enum logic [1:0] {
        S_SYNC,
        S_SETTLE,
        S_HOLD
    } state_e;

endpackage

// File: rtl/seg7_capture_if.sv
// Display-bus side of the capture block: scanned digit/segment lines in,
// committed frame and status pulses out.
interface seg7_capture_if #(
    parameter int NUM_DIG = 4
);
    logic [NUM_DIG-1:0]   an_i;
    logic [6:0]           seg_i;
    logic [4*NUM_DIG-1:0] digits_o;
    logic                 frame_valid_o;
    logic                 err_o;
    logic                 seq_err_o;

    modport master (
        output an_i, seg_i,
        input  digits_o, frame_valid_o, err_o, seq_err_o
    );

    modport slave (
        input  an_i, seg_i,
        output digits_o, frame_valid_o, err_o, seq_err_o
    );
endinterface

// File: rtl/seg7_enc.sv
// Reverse segment mapping: 7-bit pattern to hex value, valid low for any
// pattern outside the 16-entry table (including blank).
module seg7_enc
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       valid_o,
    output logic [3:0] val_o
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
        valid_o = 1'b1;
        val_o   = 4'h0;
        case (seg_i)
            SEG_0:   val_o = 4'h0;
            SEG_1:   val_o = 4'h1;
            SEG_2:   val_o = 4'h2;
            SEG_3:   val_o = 4'h3;
            SEG_4:   val_o = 4'h4;
            SEG_5:   val_o = 4'h5;
            SEG_6:   val_o = 4'h6;
            SEG_7:   val_o = 4'h7;
            SEG_8:   val_o = 4'h8;
            SEG_9:   val_o = 4'h9;
            SEG_A:   val_o = 4'hA;
            SEG_B:   val_o = 4'hB;
            SEG_C:   val_o = 4'hC;
            SEG_D:   val_o = 4'hD;
            SEG_E:   val_o = 4'hE;
            SEG_F:   val_o = 4'hF;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Monitors a time-multiplexed 7-segment bus, accepts each digit once it has
// been stable long enough, and publishes the decoded frame with a valid pulse.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIG    = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    seg7_capture_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_DIG);
    localparam int CNT_W = $clog2(STABLE_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e               state_q, state_d;
    logic [NUM_DIG-1:0]   an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [4*NUM_DIG-1:0] shadow_q, shadow_d;
    logic [NUM_DIG-1:0]   bad_q, bad_d;
    logic [4*NUM_DIG-1:0] digits_q, digits_d;
    logic                 err_q, err_d;
    logic                 fv_q, fv_d;
    logic                 seq_err_q, seq_err_d;

    logic                 enc_valid;
    logic [3:0]           enc_val;
    logic [IDX_W-1:0]     idx_nxt;
    logic [NUM_DIG-1:0]   sel_bit, next_bit;
    logic                 eq, an_zero;

    seg7_enc u_enc (
        .seg_i   (bus.seg_i),
        .valid_o (enc_valid),
        .val_o   (enc_val)
    );

    assign idx_nxt  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    assign sel_bit  = NUM_DIG'(1) << idx_q;
    assign next_bit = NUM_DIG'(1) << idx_nxt;
    assign eq       = (bus.an_i == an_q) && (bus.seg_i == seg_q);
    assign an_zero  = (bus.an_i == '0);

    always_comb begin
        an_d      = bus.an_i;
        seg_d     = bus.seg_i;
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        bad_d     = bad_q;
        digits_d  = digits_q;
        err_d     = err_q;
        fv_d      = 1'b0;
        seq_err_d = 1'b0;

        case (state_q)
            S_SYNC: begin
                if (bus.an_i == NUM_DIG'(1)) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (bus.an_i == sel_bit) begin
                    if (!eq) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        shadow_d[4*idx_q +: 4] = enc_val;
                        bad_d[idx_q]           = ~enc_valid;
                        state_d                = S_HOLD;
                        // The last digit commits together with the rest of the shadow frame.
                        if (idx_q == IDX_LAST) begin
                            digits_d = shadow_d;
                            err_d    = |bad_d;
                            fv_d     = 1'b1;
                        end
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (an_zero) begin
                    cnt_d = '0;
                end else begin
                    seq_err_d = 1'b1;
                    shadow_d  = '0;
                    bad_d     = '0;
                    state_d   = S_SYNC;
                end
            end

            S_HOLD: begin
                if (!(bus.an_i == sel_bit || an_zero)) begin
                    if (bus.an_i == next_bit) begin
                        idx_d   = idx_nxt;
                        cnt_d   = '0;
                        state_d = S_SETTLE;
                    end else begin
                        seq_err_d = 1'b1;
                        shadow_d  = '0;
                        bad_d     = '0;
                        state_d   = S_SYNC;
                    end
                end
            end

            default: state_d = S_SYNC;
        endcase
    end

    // NOTE: the shadow frame is a handful of flops, so it is cleared on reset and a
    // partial frame can never leak into a later commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_SYNC;
            an_q      <= '0;
            seg_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            bad_q     <= '0;
            digits_q  <= '0;
            err_q     <= 1'b0;
            fv_q      <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q   <= state_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            bad_q     <= bad_d;
            digits_q  <= digits_d;
            err_q     <= err_d;
            fv_q      <= fv_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign bus.digits_o      = digits_q;
    assign bus.frame_valid_o = fv_q;
    assign bus.err_o         = err_q;
    assign bus.seq_err_o     = seq_err_q;

endmodule
